ps2kb_command_scheduler: RTL and testbench

Host-to-keyboard command scheduler for the PS/2 keyboard path. It arbitrates between two requesters: CPU-issued commands and automatic lock-LED updates. It sequences each command byte and optional argument byte to the PS/2 transmitter, then consumes the keyboard's ACK (FA) or RESEND (FE) from the receive path, with timeout and bounded retry. It sits beside the scancode decoder, which receives every byte this block does not consume.

---
 rtl/ps2kb_pkg.sv | 23 ++
 rtl/ps2kb_ack_timer.sv | 29 ++
 rtl/ps2kb_command_scheduler.sv | 158 +++++++++++++++
 tb/tb_ps2kb_command_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2kb_pkg.sv
// Shared types and constants for the PS/2 keyboard host-command path.
// Holds the scheduler state encoding, the requester id and the protocol bytes.
// No logic lives here.
package ps2kb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_CMD,
        ST_WAIT_CMD_ACK,
        ST_SEND_ARG,
        ST_WAIT_ARG_ACK
    } state_t;

    typedef enum logic {
        REQ_HOST,
        REQ_LED
    } req_id_t;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_ACK         = 8'hFA;
    localparam logic [7:0] PS2_RESEND      = 8'hFE;

endpackage

// File: rtl/ps2kb_ack_timer.sv
// ACK timeout counter: counts cycles while enabled; expired is high in the cycle the count reaches TIMEOUT_CYCLES-1.
// Latency: expired is combinational from the count; the count is zero in the first enabled cycle after clear.
// Backpressure: none; the owner clears it whenever it is not waiting for a reply.
// Ports: clock, reset (async, active-high), clear (sync), enable, expired.
module ps2kb_ack_timer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count;

    assign expired = enable && (count == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 16'd0;
        end else if (clear) begin
            count <= 16'd0;
        end else if (enable && !expired) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/ps2kb_command_scheduler.sv
// Host-to-keyboard command scheduler: arbitrates CPU commands and lock-LED updates, sends cmd/arg bytes, handles FA/FE, timeout and retry.
// Latency: host_req in cycle N gives host_busy and tx_valid in cycle N+1; completion pulses coincide with the return to IDLE.
// Backpressure: tx_valid/tx_data held until tx_ready; host_req while busy is dropped. Optional LED requester: define PS2KB_LED_AUTO_EN.
// Ports: clock/reset; host_req/cmd/arg/has_arg -> host_busy/done/error; led_state -> led_error;
//        tx_valid/tx_data/tx_ready to the transmitter; rx_valid/rx_data from the receiver, rx_consume to the decoder.
module ps2kb_command_scheduler
    import ps2kb_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000,
    parameter int          MAX_RETRY      = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       host_req,
    input  logic [7:0] host_cmd,
    input  logic [7:0] host_arg,
    input  logic       host_has_arg,
    output logic       host_busy,
    output logic       host_done,
    output logic       host_error,
    input  logic [2:0] led_state,
    output logic       led_error,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_consume
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t               state;
    req_id_t              req;
    logic [7:0]           cmd_byte;
    logic [7:0]           arg_byte;
    logic                 has_arg;
    logic [RETRY_W-1:0]   retry;
    logic                 in_wait;
    logic                 ack_seen;
    logic                 nak_seen;
    logic                 expired;

    assign in_wait    = (state == ST_WAIT_CMD_ACK) || (state == ST_WAIT_ARG_ACK);
    assign ack_seen   = in_wait && rx_valid && (rx_data == PS2_ACK);
    assign nak_seen   = in_wait && rx_valid && (rx_data == PS2_RESEND);
    assign rx_consume = ack_seen || nak_seen;
    assign host_busy  = (state != ST_IDLE);

    // Held clear outside WAIT, so the count always starts from zero on WAIT entry.
    ps2kb_ack_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ack_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (!in_wait),
        .enable  (in_wait),
        .expired (expired)
    );

`ifdef PS2KB_LED_AUTO_EN
    logic [2:0] led_last;
    logic       led_error_q;
    assign led_error = led_error_q;
`else
    logic unused_led;
    assign unused_led = ^led_state;
    assign led_error  = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            req        <= REQ_HOST;
            cmd_byte   <= 8'h00;
            arg_byte   <= 8'h00;
            has_arg    <= 1'b0;
            retry      <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            host_done  <= 1'b0;
            host_error <= 1'b0;
`ifdef PS2KB_LED_AUTO_EN
            led_last    <= 3'b000;
            led_error_q <= 1'b0;
`endif
        end else begin
            host_done  <= 1'b0;
            host_error <= 1'b0;
`ifdef PS2KB_LED_AUTO_EN
            led_error_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (host_req) begin
                        req      <= REQ_HOST;
                        cmd_byte <= host_cmd;
                        arg_byte <= host_arg;
                        has_arg  <= host_has_arg;
                        retry    <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= host_cmd;
                        state    <= ST_SEND_CMD;
                    end
`ifdef PS2KB_LED_AUTO_EN
                    // Only the value seen at start is sent; later changes coalesce into the next update.
                    else if (led_state != led_last) begin
                        req      <= REQ_LED;
                        cmd_byte <= PS2_CMD_SET_LED;
                        arg_byte <= {5'b00000, led_state};
                        has_arg  <= 1'b1;
                        retry    <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= PS2_CMD_SET_LED;
                        state    <= ST_SEND_CMD;
                    end
`endif
                end
                ST_SEND_CMD, ST_SEND_ARG: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= (state == ST_SEND_CMD) ? ST_WAIT_CMD_ACK : ST_WAIT_ARG_ACK;
                    end
                end
                ST_WAIT_CMD_ACK, ST_WAIT_ARG_ACK: begin
                    // An ACK wins over a coincident timeout; stray bytes leave everything untouched.
                    if (ack_seen && (state == ST_WAIT_CMD_ACK) && has_arg) begin
                        retry    <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= arg_byte;
                        state    <= ST_SEND_ARG;
                    end else if ((nak_seen || (expired && !ack_seen)) &&
                                 (retry < RETRY_W'(MAX_RETRY))) begin
                        retry    <= retry + RETRY_W'(1);
                        tx_valid <= 1'b1;
                        tx_data  <= (state == ST_WAIT_CMD_ACK) ? cmd_byte : arg_byte;
                        state    <= (state == ST_WAIT_CMD_ACK) ? ST_SEND_CMD : ST_SEND_ARG;
                    end else if (ack_seen || nak_seen || expired) begin
                        state <= ST_IDLE;
                        if (req == REQ_HOST) begin
                            host_done  <= ack_seen;
                            host_error <= !ack_seen;
                        end
`ifdef PS2KB_LED_AUTO_EN
                        else begin
                            // Recorded even on failure so a dead keyboard cannot cause an endless update loop.
                            led_last    <= arg_byte[2:0];
                            led_error_q <= !ack_seen;
                        end
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2kb_command_scheduler.sv
// Directed bench for ps2kb_command_scheduler with a shortened ACK timeout.
// Builds with or without PS2KB_LED_AUTO_EN.
module tb_ps2kb_command_scheduler;

    localparam logic [15:0] T  = 16'd40;
    localparam int          MR = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       host_req;
    logic [7:0] host_cmd;
    logic [7:0] host_arg;
    logic       host_has_arg;
    logic       host_busy;
    logic       host_done;
    logic       host_error;
    logic [2:0] led_state;
    logic       led_error;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_consume;

    ps2kb_command_scheduler #(
        .TIMEOUT_CYCLES(T),
        .MAX_RETRY(MR)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .host_req     (host_req),
        .host_cmd     (host_cmd),
        .host_arg     (host_arg),
        .host_has_arg (host_has_arg),
        .host_busy    (host_busy),
        .host_done    (host_done),
        .host_error   (host_error),
        .led_state    (led_state),
        .led_error    (led_error),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_consume   (rx_consume)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor: a value sampled at edge k was driven by edge k-1.
    int         cyc = 0;
    int         last_tx_cyc = 0;
    int         err_cyc = 0;
    int         n_done = 0;
    int         n_err = 0;
    int         n_lerr = 0;
    logic [7:0] txq[$];

    always @(posedge clock) begin
        cyc++;
        if (!reset) begin
            if (tx_valid && tx_ready) begin
                txq.push_back(tx_data);
                last_tx_cyc = cyc;
            end
            if (host_done)  n_done++;
            if (host_error) begin
                n_err++;
                err_cyc = cyc;
            end
            if (led_error)  n_lerr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp, input int budget);
        int k = 0;
        while (txq.size() == 0 && k < budget) begin
            tick();
            k++;
        end
        if (txq.size() == 0) check({tag, "_no_tx"}, 32'd0, 32'd1);
        else                 check(tag, {24'd0, txq.pop_front()}, {24'd0, exp});
    endtask

    task automatic reply(input string tag, input logic [7:0] b, input logic exp_consume);
        rx_valid = 1'b1;
        rx_data  = b;
        #2;
        check(tag, {31'd0, rx_consume}, {31'd0, exp_consume});
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic start_host(input logic [7:0] c, input logic [7:0] a, input logic h);
        host_req     = 1'b1;
        host_cmd     = c;
        host_arg     = a;
        host_has_arg = h;
        tick();
        host_req     = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int d0;
        int e0;
        int k;
        reset = 1'b1; host_req = 1'b0; host_cmd = 8'h00; host_arg = 8'h00; host_has_arg = 1'b0;
        led_state = 3'b000; tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'hFA;
        repeat (3) tick();
        reset = 1'b0;
        #2;
        // Reset values; an FA in IDLE is not consumed.
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check("rst_busy", {31'd0, host_busy}, 32'd0);
        check("rst_pulses", {29'd0, host_done, host_error, led_error}, 32'd0);
        check("rst_idle_consume", {31'd0, rx_consume}, 32'd0);
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick();

        // Host single byte F4.
        start_host(8'hF4, 8'h00, 1'b0);
        check("t1_busy", {31'd0, host_busy}, 32'd1);
        check("t1_tx_valid", {31'd0, tx_valid}, 32'd1);
        check("t1_tx_data", {24'd0, tx_data}, 32'hF4);
        wait_tx("t1_tx", 8'hF4, 5);
        reply("t1_consume_fa", 8'hFA, 1'b1);
        check("t1_done", {31'd0, host_done}, 32'd1);
        check("t1_busy_low", {31'd0, host_busy}, 32'd0);
        tick();
        check("t1_done_one_cycle", {31'd0, host_done}, 32'd0);
        check("t1_tx_count", txq.size(), 32'd0);

        // Host with argument, transmitter stalled, stray byte and ignored request while busy.
        tx_ready = 1'b0;
        start_host(8'hF3, 8'h20, 1'b1);
        repeat (3) tick();
        check("t2_hold_valid", {31'd0, tx_valid}, 32'd1);
        check("t2_hold_data", {24'd0, tx_data}, 32'hF3);
        check("t2_no_tx_stalled", txq.size(), 32'd0);
        tx_ready = 1'b1;
        wait_tx("t2_tx_cmd", 8'hF3, 5);
        host_req = 1'b1; host_cmd = 8'hEE; host_has_arg = 1'b0;
        tick();
        host_req = 1'b0;
        reply("t2_consume_fa1", 8'hFA, 1'b1);
        wait_tx("t2_tx_arg", 8'h20, 5);
        reply("t2_stray_1c", 8'h1C, 1'b0);
        check("t2_busy_after_stray", {31'd0, host_busy}, 32'd1);
        reply("t2_consume_fa2", 8'hFA, 1'b1);
        check("t2_done", {31'd0, host_done}, 32'd1);
        repeat (3) tick();
        check("t2_busy_req_dropped", {31'd0, host_busy}, 32'd0);
        check("t2_tx_count", txq.size(), 32'd0);

        // Resend then timeout exhaustion: 3 transmissions, error T cycles after the last.
        d0 = n_done;
        e0 = n_err;
        start_host(8'hF4, 8'h00, 1'b0);
        wait_tx("t3_tx1", 8'hF4, 5);
        reply("t3_consume_fe", 8'hFE, 1'b1);
        wait_tx("t3_tx2", 8'hF4, 5);
        wait_tx("t3_tx3", 8'hF4, T + 5);
        k = 0;
        while (n_err == e0 && k < T + 10) begin
            tick();
            k++;
        end
        check("t3_error_count", n_err - e0, 32'd1);
        // Monitor cycle of the error is one past the edge that raised it.
        check("t3_error_delay", err_cyc - last_tx_cyc, T + 1);
        check("t3_no_done", n_done - d0, 32'd0);
        repeat (T + 5) tick();
        check("t3_no_4th_tx", txq.size(), 32'd0);
        check("t3_idle", {31'd0, host_busy}, 32'd0);

        // FA in the very cycle the timeout expires counts as success.
        start_host(8'h55, 8'h00, 1'b0);
        wait_tx("t4_tx", 8'h55, 5);
        repeat (T - 1) tick();
        reply("t4_consume_deadline", 8'hFA, 1'b1);
        check("t4_done", {31'd0, host_done}, 32'd1);
        check("t4_no_retx", txq.size(), 32'd0);
        tick();

`ifdef PS2KB_LED_AUTO_EN
        // LED auto-update.
        d0 = n_done;
        led_state = 3'b101;
        tick();
        check("t5_busy", {31'd0, host_busy}, 32'd1);
        wait_tx("t5_tx_ed", 8'hED, 5);
        reply("t5_fa1", 8'hFA, 1'b1);
        wait_tx("t5_tx_arg", 8'h05, 5);
        reply("t5_fa2", 8'hFA, 1'b1);
        repeat (10) tick();
        check("t5_no_host_pulse", n_done - d0, 32'd0);
        check("t5_no_led_error", n_lerr, 32'd0);
        check("t5_quiet", txq.size(), 32'd0);

        // Collision: host wins, LED update follows straight after.
        led_state = 3'b011;
        start_host(8'hF4, 8'h00, 1'b0);
        wait_tx("t6_host_first", 8'hF4, 5);
        reply("t6_stray_1c", 8'h1C, 1'b0);
        reply("t6_fa", 8'hFA, 1'b1);
        check("t6_done", {31'd0, host_done}, 32'd1);
        tick();
        check("t6_led_follows", {31'd0, host_busy}, 32'd1);
        check("t6_led_data", {24'd0, tx_data}, 32'hED);
        wait_tx("t6_tx_ed", 8'hED, 5);
        reply("t6_fa1", 8'hFA, 1'b1);
        wait_tx("t6_tx_arg", 8'h03, 5);
        reply("t6_fa2", 8'hFA, 1'b1);
        tick();
`else
        // LED requester absent: led_state changes are ignored.
        led_state = 3'b101;
        repeat (5) tick();
        check("t5_led_ignored_tx", txq.size(), 32'd0);
        check("t5_led_ignored_busy", {31'd0, host_busy}, 32'd0);
        check("t5_led_error_tied", {31'd0, led_error}, 32'd0);
`endif

        // Reset during SEND_ARG.
        d0 = n_done;
        e0 = n_err;
        start_host(8'hF3, 8'h20, 1'b1);
        wait_tx("t7_tx_cmd", 8'hF3, 5);
        tx_ready = 1'b0;
        reply("t7_fa", 8'hFA, 1'b1);
        check("t7_send_arg_valid", {31'd0, tx_valid}, 32'd1);
        check("t7_send_arg_data", {24'd0, tx_data}, 32'h20);
        reset = 1'b1;
        #1;
        check("t7_async_drop", {31'd0, tx_valid}, 32'd0);
        check("t7_busy_drop", {31'd0, host_busy}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tx_ready = 1'b1;
        repeat (3) tick();
        check("t7_no_pulses", (n_done - d0) + (n_err - e0), 32'd0);
`ifdef PS2KB_LED_AUTO_EN
        wait_tx("t7_led_retrigger", 8'hED, 5);
        reply("t7_fa1", 8'hFA, 1'b1);
        wait_tx("t7_led_arg", 8'h03, 5);
        reply("t7_fa2", 8'hFA, 1'b1);
        check("t7_no_led_error", n_lerr, 32'd0);
`else
        check("t7_no_tx_after_reset", txq.size(), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
